// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
package bus_arb_pkg;

    localparam int unsigned N_MAX = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Index width for n masters (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Utilization counter width; must hold the full window count.
    function automatic int unsigned util_w(input int unsigned win);
        return $clog2(win) + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between bus masters and the round-robin arbiter.
interface bus_arbiter_rr_if
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 6,
    parameter int unsigned UTIL_WIN  = 1024
);
    localparam int unsigned IW = idx_w(N_MASTERS);
    localparam int unsigned UW = util_w(UTIL_WIN);

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] hold;
    logic                 done;
    logic [N_MASTERS-1:0] grant;
    logic [IW-1:0]        grant_id;
    logic                 bus_busy;
    logic [UW-1:0]        util_count;
    logic                 timeout_err;

    modport master (
        output req, hold, done,
        input  grant, grant_id, bus_busy, util_count, timeout_err
    );

    modport slave (
        input  req, hold, done,
        output grant, grant_id, bus_busy, util_count, timeout_err
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of i_req at or after i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 6,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (i_req[(32'(i_ptr) + 32'(k)) % N]) begin
                o_found = 1'b1;
                o_idx   = IW'((32'(i_ptr) + 32'(k)) % N);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with lock/hold, abort on request drop and utilization window counter.
// Optional grant timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 6,
    parameter int unsigned UTIL_WIN  = 1024,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic            in_clk,
    input  logic            rstn,
    bus_arbiter_rr_if.slave bus
);

    localparam int unsigned IW = idx_w(N_MASTERS);
    localparam int unsigned UW = util_w(UTIL_WIN);
    localparam int unsigned WW = $clog2(UTIL_WIN);

    if (N_MASTERS < 2 || N_MASTERS > N_MAX || UTIL_WIN < 4 ||
        (UTIL_WIN & (UTIL_WIN - 1)) != 0 || TIMEOUT < 2) begin : g_cfg_err
        $error("bus_arbiter_rr: illegal parameter set");
    end

    arb_state_e           r_state;
    logic                 r_busy;
    logic [IW-1:0]        r_grant_id;
    logic [N_MASTERS-1:0] r_grant;
    logic [IW-1:0]        r_rr_ptr;
    logic [WW-1:0]        r_win_cnt;
    logic [UW-1:0]        r_util_acc;
    logic [UW-1:0]        r_util_count;

    arb_state_e           w_state_n;
    logic                 w_busy_n;
    logic [IW-1:0]        w_id_n;
    logic                 w_new_grant;
    logic [IW-1:0]        w_new_id;
    logic [N_MASTERS-1:0] w_pick_mask;
    logic                 w_found;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_g_req;
    logic                 w_keep;
    logic                 w_release;
    logic                 w_tmo;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] i);
        return (i == IW'(N_MASTERS - 1)) ? '0 : i + IW'(1);
    endfunction

    assign w_g_req     = bus.req[r_grant_id];
    assign w_keep      = bus.done && bus.hold[r_grant_id] && w_g_req;
    assign w_release   = bus.done || !w_g_req || w_tmo;
    // While owned, the current owner is masked out so others get the next turn.
    assign w_pick_mask = (r_state == OWNED) ? (bus.req & ~(N_MASTERS'(1) << r_grant_id))
                                            : bus.req;

    rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .i_req   (w_pick_mask),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    // Next-state and grant selection.
    always_comb begin
        w_state_n   = r_state;
        w_busy_n    = r_busy;
        w_id_n      = r_grant_id;
        w_new_grant = 1'b0;
        w_new_id    = w_pick_idx;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n   = OWNED;
                    w_busy_n    = 1'b1;
                    w_new_grant = 1'b1;
                end
            end
            OWNED: begin
                if (!w_keep && w_release) begin
                    if (w_found) begin
                        w_new_grant = 1'b1;
                    end else if (w_g_req) begin
                        w_new_grant = 1'b1;
                        w_new_id    = r_grant_id;
                    end else begin
                        w_state_n = IDLE;
                        w_busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
        if (w_new_grant) begin
            w_id_n = w_new_id;
        end else if (!w_busy_n) begin
            w_id_n = '0;
        end
    end

    always_ff @(posedge in_clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_n;
            r_busy     <= w_busy_n;
            r_grant_id <= w_id_n;
            r_grant    <= w_busy_n ? (N_MASTERS'(1) << w_id_n) : '0;
            if (w_new_grant) begin
                r_rr_ptr <= ptr_inc(w_new_id);
            end
        end
    end

    // Free-running window; the last cycle's busy bit is folded into the published count.
    always_ff @(posedge in_clk or negedge rstn) begin
        if (!rstn) begin
            r_win_cnt    <= '0;
            r_util_acc   <= '0;
            r_util_count <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + WW'(1);
            if (&r_win_cnt) begin
                r_util_count <= r_util_acc + UW'(r_busy);
                r_util_acc   <= '0;
            end else begin
                r_util_acc <= r_util_acc + UW'(r_busy);
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned AW = $clog2(TIMEOUT + 1);

    logic [AW-1:0] r_age;
    logic          r_timeout_err;

    // Age 0 on the first owned cycle, so a grant lives exactly TIMEOUT cycles.
    assign w_tmo = (r_state == OWNED) && !bus.done && (r_age == AW'(TIMEOUT - 1));

    always_ff @(posedge in_clk or negedge rstn) begin
        if (!rstn) begin
            r_age         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_tmo;
            if (w_new_grant || bus.done) begin
                r_age <= '0;
            end else if (r_state == OWNED) begin
                r_age <= r_age + AW'(1);
            end
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_tmo           = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant      = r_grant;
    assign bus.grant_id   = r_grant_id;
    assign bus.bus_busy   = r_busy;
    assign bus.util_count = r_util_count;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: directed request patterns, expected grants queued, monitor compares.
module tb_bus_arbiter_rr;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TB_TMO = 8;
`else
    localparam int unsigned TB_TMO = 255;
`endif

    logic in_clk;
    logic rstn;

    bus_arbiter_rr_if #(.N_MASTERS(6), .UTIL_WIN(16)) bif ();

    bus_arbiter_rr #(
        .N_MASTERS (6),
        .UTIL_WIN  (16),
        .TIMEOUT   (TB_TMO)
    ) dut (
        .in_clk (in_clk),
        .rstn   (rstn),
        .bus    (bif.slave)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int         n_cmp;
    int         n_err;
    int         tmo_seen;
    bit         util_on;
    logic [5:0] q_grant[$];
    int         q_util[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    function automatic int onehot_idx(input logic [5:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic monitor();
        logic [5:0] prev_g;
        int         prev_u;
        logic [5:0] exp_g;
        prev_g = '0;
        prev_u = 0;
        forever begin
            @(negedge in_clk);
            if (bif.timeout_err) tmo_seen++;
            if (rstn && bif.grant != prev_g) begin
                if (q_grant.size() == 0) begin
                    chk("grant_unexpected_change", int'(bif.grant), int'(prev_g));
                end else begin
                    exp_g = q_grant.pop_front();
                    chk("grant", int'(bif.grant), int'(exp_g));
                    chk("bus_busy", int'(bif.bus_busy), int'(exp_g != 0));
                    if (exp_g != 0) chk("grant_id", int'(bif.grant_id), onehot_idx(exp_g));
                end
            end
            if (rstn && util_on && int'(bif.util_count) != prev_u) begin
                if (q_util.size() == 0) chk("util_unexpected_change", int'(bif.util_count), prev_u);
                else chk("util_count", int'(bif.util_count), q_util.pop_front());
            end
            prev_g = bif.grant;
            prev_u = int'(bif.util_count);
        end
    endtask

    // Assert reset off-edge, check the outputs cleared without a clock, release on a falling edge.
    task automatic do_reset();
        @(negedge in_clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_grant", int'(bif.grant), 0);
        chk("rst_grant_id", int'(bif.grant_id), 0);
        chk("rst_bus_busy", int'(bif.bus_busy), 0);
        chk("rst_util_count", int'(bif.util_count), 0);
        chk("rst_timeout_err", int'(bif.timeout_err), 0);
        cyc(2);
        rstn = 1'b1;
    endtask

    task automatic pulse_done();
        bif.done = 1'b1;
        cyc(1);
        bif.done = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; tmo_seen = 0; util_on = 1'b0;
        rstn = 1'b0;
        bif.req = '0; bif.hold = '0; bif.done = 1'b0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Lowest requester from ptr 0, then hand-over on done with no idle gap.
        do_reset();
        bif.req = 6'b000101; q_grant.push_back(6'b000001);
        cyc(1);
        q_grant.push_back(6'b000100);
        pulse_done();
        bif.req = '0; q_grant.push_back(6'b000000);
        cyc(2);

        // Full contention: strict rotation 0..5 then back to 0.
        do_reset();
        bif.req = 6'b111111; q_grant.push_back(6'b000001);
        for (int i = 1; i <= 6; i++) begin
            cyc(3);
            q_grant.push_back(6'(1) << (i % 6));
            pulse_done();
        end
        bif.req = '0; q_grant.push_back(6'b000000);
        cyc(2);

        // Locked owner keeps the bus over several dones, then yields.
        do_reset();
        bif.req = 6'b001000; bif.hold = 6'b001000; q_grant.push_back(6'b001000);
        cyc(1);
        bif.req = 6'b001001;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            pulse_done();
        end
        cyc(1);
        chk("hold_keeps_grant", int'(bif.grant), int'(6'b001000));
        bif.hold = '0;
        q_grant.push_back(6'b000001);
        pulse_done();
        bif.req = 6'b000001;
        cyc(1);
        pulse_done();
        cyc(1);
        chk("sole_requester_regrant", int'(bif.grant), int'(6'b000001));
        chk("sole_requester_busy", int'(bif.bus_busy), 1);
        bif.req = '0; q_grant.push_back(6'b000000);
        cyc(2);
        pulse_done();
        cyc(1);
        chk("done_in_idle_ignored", int'(bif.grant), 0);

        // Utilization windows of 16: 10 busy, 0 busy, 16 busy; then reset mid-window.
        do_reset();
        util_on = 1'b1;
        bif.req = 6'b000001; q_grant.push_back(6'b000001);
        q_util.push_back(10); q_util.push_back(0); q_util.push_back(16);
        cyc(10);
        bif.req = '0; q_grant.push_back(6'b000000);
        cyc(21);
        bif.req = 6'b000010; q_grant.push_back(6'b000010);
        cyc(21);
        chk("util_queue_drained", q_util.size(), 0);
        chk("util_last_window", int'(bif.util_count), 16);
        util_on = 1'b0;
        do_reset();
        bif.req = 6'b010000; q_grant.push_back(6'b010000);
        cyc(1);
        bif.req = '0; q_grant.push_back(6'b000000);
        cyc(3);

`ifdef BUS_ARB_TIMEOUT_EN
        // Grant held TIMEOUT cycles without done is revoked, next requester takes over.
        do_reset();
        tmo_seen = 0;
        bif.req = 6'b000100; q_grant.push_back(6'b000100);
        cyc(1);
        bif.req = 6'b000110;
        cyc(7);
        chk("tmo_not_yet_grant", int'(bif.grant), int'(6'b000100));
        chk("tmo_not_yet_pulse", tmo_seen, 0);
        q_grant.push_back(6'b000010);
        cyc(3);
        bif.req = '0; q_grant.push_back(6'b000000);
        cyc(3);
        chk("tmo_single_pulse", tmo_seen, 1);
`else
        chk("no_timeout_pulses", tmo_seen, 0);
`endif

        cyc(2);
        chk("grant_queue_drained", q_grant.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter N_MASTERS, default 6, number of bus masters (2..16).
REQ-002 SHALL have parameter UTIL_WIN, default 1024, utilization measurement window in cycles (power of two, >=4).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles a grant may be held without done (>=2).
REQ-004 SHALL have port in_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  N_MASTERS  per-master bus request, level.
REQ-007 SHALL have port hold  input  N_MASTERS  per-master lock request; keeps the bus across consecutive transactions.
REQ-008 SHALL have port done  input  1  one-cycle pulse, current transaction complete.
REQ-009 SHALL have port grant  output  N_MASTERS  one-hot grant, registered.
REQ-010 SHALL have port grant_id  output  clog2(N_MASTERS)  index of granted master, valid when bus_busy=1.
REQ-011 SHALL have port bus_busy  output  1  high while any grant is active.
REQ-012 SHALL have port util_count  output  clog2(UTIL_WIN)+1  busy cycles in the last completed window.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on grant revocation by timeout.

Function
REQ-014 SHALL implement states IDLE (no grant) and OWNED (one grant active).
REQ-015 IDLE: SHALL, when any req is high, assign grant on the next edge to the first requester at or after rr_ptr (wrapping), and enter OWNED; 1-cycle req-to-grant latency.
REQ-016 On every new grant to master i, rr_ptr SHALL become (i+1) mod N_MASTERS.
REQ-017 OWNED: on done with hold[g]=1 and req[g]=1, grant SHALL stay on g; rr_ptr unchanged.
REQ-018 OWNED: on done otherwise, SHALL re-arbitrate in the same edge from rr_ptr, excluding g; no idle cycle between owners; if no other requester and req[g]=1, g is re-granted; if no requester, go IDLE.
REQ-019 OWNED: req[g] falling without done SHALL drop grant next edge (abort) and re-arbitrate as in REQ-018.
REQ-020 done while IDLE SHALL be ignored.
REQ-021 grant SHALL never have more than one bit set; grant=0 iff bus_busy=0.
REQ-022 A grant-age counter SHALL reset on each new grant/done and increment each OWNED cycle; util counter and window counter SHALL be free-running.
REQ-023 util_count SHALL update on the last cycle of each UTIL_WIN window with the number of bus_busy=1 cycles in that window (value UTIL_WIN possible; no overflow).

Reset
REQ-024 rstn low SHALL immediately force grant=0, grant_id=0, bus_busy=0, util_count=0, timeout_err=0, rr_ptr=0, state IDLE, all counters 0.
REQ-025 Reset mid-transaction SHALL abandon the owner; first post-reset grant follows REQ-015 from rr_ptr=0.

Configuration
REQ-026 With macro BUS_ARB_TIMEOUT_EN defined: grant-age reaching TIMEOUT SHALL revoke the grant next edge, pulse timeout_err for one cycle, and re-arbitrate excluding g per REQ-018 (hold ignored).
REQ-027 Without BUS_ARB_TIMEOUT_EN: no age counter, grants persist until done or req drop, timeout_err tied 0.

Structure
REQ-028 Shared package bus_arb_pkg SHALL hold the state enum (IDLE, OWNED) and width helper constants.
REQ-029 Sub-module rr_pick SHALL be the combinational rotating-priority picker (inputs req mask, ptr; outputs found, index).

Verification
REQ-030 Reset, then req=6'b000101 -> grant=000001 one cycle later, rr_ptr=1; done -> grant=000100 next edge, no idle gap.
REQ-031 All six req high, done every 4 cycles -> grant order 0,1,2,3,4,5,0; each master once per 6 transactions.
REQ-032 Master 3 owns with hold[3]=1, req[0]=1, three done pulses -> grant stays 001000; hold[3] drops, next done -> grant=000001.
REQ-033 BUS_ARB_TIMEOUT_EN, TIMEOUT=8, master 2 granted, no done -> revoke after 8 OWNED cycles, timeout_err single pulse, next requester granted.
REQ-034 UTIL_WIN=16, bus busy 10 of 16 cycles -> util_count=10 after window end; always busy -> 16; idle -> 0.
REQ-035 rstn asserted during OWNED mid-window -> all outputs 0 asynchronously; after release, req[4] alone -> grant=010000 in one cycle.
